video_timing: RTL and testbench
===============================

Name: video_timing

Overview:
- Generates raster timing (sync, blanking, scan position) for the video output path.
- Consumes OUTPUT_CTRL and VIDEO_MODE from the control register file's values_out bus.
- Produces the values for the read-only SCAN_X, SCAN_Y and OUTPUT_STATUS registers, which feed the register file's values_in bus.
- Sits between the control registers and the pixel pipeline / DAC.

Parameters:
- DATA_WIDTH, 16, register bus width; all register-facing ports use this width.
- CLK_DIV, 2, system clocks per pixel; must be >= 1.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- COUNT_WIDTH, 10, width of the h/v counters; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- output_ctrl  input  DATA_WIDTH  OUTPUT_CTRL value; bit0 = timing enable.
- video_mode  input  DATA_WIDTH  VIDEO_MODE value; bit0 = hsync active-high, bit1 = vsync active-high.
- scan_x  output  DATA_WIDTH  current h count, zero-extended; feeds SCAN_X.
- scan_y  output  DATA_WIDTH  current v count, zero-extended; feeds SCAN_Y.
- output_status  output  DATA_WIDTH  feeds OUTPUT_STATUS: bit0 vblank, bit1 hblank, bit2 enabled, others 0.
- hsync  output  1  horizontal sync, polarity per the shadowed mode.
- vsync  output  1  vertical sync, polarity per the shadowed mode.
- display_en  output  1  high while in the visible region.
- pixel_tick  output  1  one-clk pulse per pixel period.
- line_start  output  1  one-clk pulse when h wraps to 0.
- vblank_start  output  1  one-clk pulse when v becomes V_VISIBLE.
- frame_count  output  DATA_WIDTH  count of completed frames.

Behaviour:
- Derived values: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Clock reset and polarity: clk is the only clock. Reset is synchronous, active-high, and takes effect on the clk edge even mid-frame.
- Reset state:
  - h, v, div counter, frame_count: 0.
  - Polarity shadow: 0, meaning both syncs active-low, so hsync=vsync=1 (inactive).
  - display_en, pixel_tick, line_start, vblank_start: 0; output_status=0.
- Divider: div counts 0..CLK_DIV-1 while enabled. pixel_tick=1 for the clk in which div==CLK_DIV-1. With CLK_DIV=1, pixel_tick is high every clk.
- Counters:
  - On each pixel_tick, h increments.
  - At h==H_TOTAL-1, h wraps to 0 and v increments.
  - At v==V_TOTAL-1 with h wrapping, v wraps to 0 and frame_count increments, wrapping 0xFFFF->0.
  - Counters never exceed TOTAL-1.
- Enable (output_ctrl[0]):
  - When 0: h, v and div are forced to 0 every clk; syncs are at their inactive level; display_en=0; no pulses. frame_count holds. The polarity shadow loads continuously.
  - On a 0->1 change: counting starts at (0,0) with div=0 on the following clk.
  - A 1->0 change mid-frame aborts immediately on the next clk.
- Polarity shadow: while enabled, video_mode[1:0] is loaded only on the pixel_tick that wraps both h and v (frame boundary). Mid-frame writes take effect from the next frame.
- Decode, from the registered counters:
  - hblank = h>=H_VISIBLE.
  - hsync active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - vblank = v>=V_VISIBLE.
  - vsync active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC.
  - display_en = !hblank & !vblank.
- Latency:
  - hsync, vsync, display_en and output_status are registered from the decode, so they lag scan_x/scan_y by exactly 1 clk.
  - scan_x/scan_y are the counter registers themselves, so they have 0 latency.
  - line_start and vblank_start are asserted in the same clk in which the counters show the new value.
- Simultaneous events:
  - A frame wrap asserts line_start, increments frame_count and loads the shadow in the same clk.
  - Reset overrides enable.
  - Disable overrides a pending tick.

Decomposition:
- Shared package/header (alongside the register address defines) holds:
  - OUTPUT_CTRL bit index ENABLE=0.
  - VIDEO_MODE bit indices HSYNC_POL=0 and VSYNC_POL=1.
  - OUTPUT_STATUS bit indices VBLANK=0, HBLANK=1, ENABLED=2.
- One natural sub-module, timing_axis_counter: a parameterised wrap counter with VISIBLE, FRONT, SYNC and BACK parameters. Inputs: step, clear. Outputs: count, wrap, blank, sync_active. It is instantiated twice: h steps on pixel_tick; v steps on h wrap.

Test Plan:
- Reset then enable, CLK_DIV=2, defaults -> pixel_tick every 2nd clk; scan_x reaches 799 then wraps to 0; scan_y steps 0->1; line_start pulses exactly once.
- Run a full frame -> vblank_start pulses when scan_y=480, scan_x=0. output_status bit0 rises 1 clk later. vsync low for exactly 2 lines (1600 ticks); frame_count 0->1 at (799,524)->(0,0).
- hsync window -> hsync low for scan_x 656..751, observed one clk after the counter. display_en high only for x<640, y<480.
- Write video_mode=0x0003 at y=100 -> syncs keep active-low until the frame wrap, then become active-high (idle 0).
- Clear the enable bit at (300,200) -> next clk scan_x=scan_y=0, hsync=vsync=1, display_en=0, frame_count held. Re-enable -> restart at (0,0).
- Assert reset mid-frame for 1 clk while enabled -> all outputs at their reset values at the next clk. Counting resumes from (0,0) while enable is held.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared register bit indices and sync-polarity helpers for the raster timing generator.
package video_timing_pkg;

  localparam int OUTPUT_CTRL_ENABLE = 0;

  localparam int VIDEO_MODE_HSYNC_POL = 0;
  localparam int VIDEO_MODE_VSYNC_POL = 1;

  localparam int OUTPUT_STATUS_VBLANK  = 0;
  localparam int OUTPUT_STATUS_HBLANK  = 1;
  localparam int OUTPUT_STATUS_ENABLED = 2;

  typedef struct packed {
    logic vsync_pol;
    logic hsync_pol;
  } sync_pol_t;

  // A polarity bit of 1 means the sync pulse is driven high; idle is the complement.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrap counter over VISIBLE+FRONT+SYNC+BACK with blank/sync window decode.
module timing_axis_counter #(
  parameter int VISIBLE     = 640,
  parameter int FRONT       = 16,
  parameter int SYNC        = 96,
  parameter int BACK        = 48,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   wrap,
  output logic                   blank,
  output logic                   sync_active
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [COUNT_WIDTH-1:0] LAST       = COUNT_WIDTH'(TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] VIS_END    = COUNT_WIDTH'(VISIBLE);
  localparam logic [COUNT_WIDTH-1:0] SYNC_START = COUNT_WIDTH'(VISIBLE + FRONT);
  localparam logic [COUNT_WIDTH-1:0] SYNC_END   = COUNT_WIDTH'(VISIBLE + FRONT + SYNC);

  logic [COUNT_WIDTH-1:0] count_reg;

  assign wrap        = step && (count_reg == LAST);
  assign blank       = (count_reg >= VIS_END);
  assign sync_active = (count_reg >= SYNC_START) && (count_reg < SYNC_END);
  assign count       = count_reg;

  // Clear beats step so a disable in the same clk as a pending step still lands at 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (step) begin
      count_reg <= wrap ? '0 : count_reg + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: pixel divider, h/v scan counters, registered sync/blank decode.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_DIV     = 2,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] output_ctrl,
  input  logic [DATA_WIDTH-1:0] video_mode,
  output logic [DATA_WIDTH-1:0] scan_x,
  output logic [DATA_WIDTH-1:0] scan_y,
  output logic [DATA_WIDTH-1:0] output_status,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  display_en,
  output logic                  pixel_tick,
  output logic                  line_start,
  output logic                  vblank_start,
  output logic [DATA_WIDTH-1:0] frame_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]       DIV_LAST       = DIV_W'(CLK_DIV - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST_VISIBLE = COUNT_WIDTH'(V_VISIBLE - 1);

  logic                   enable;
  logic                   active_reg;
  logic                   decode_en;
  logic [DIV_W-1:0]       div_reg;
  logic [COUNT_WIDTH-1:0] h_count, v_count;
  logic                   h_wrap, v_wrap;
  logic                   h_blank, v_blank;
  logic                   h_sync_active, v_sync_active;
  logic                   hsync_reg, vsync_reg, display_en_reg;
  logic                   line_start_reg, vblank_start_reg;
  logic [DATA_WIDTH-1:0]  status_reg, status_next;
  logic [DATA_WIDTH-1:0]  frame_count_reg;
  sync_pol_t              pol_reg;

  assign enable = output_ctrl[OUTPUT_CTRL_ENABLE];

  // active_reg marks that counting was already live in the previous clk, so a fresh
  // enable spends its first clk at (0,0) with div held at 0.
  assign pixel_tick = active_reg && (div_reg == DIV_LAST);
  assign decode_en  = enable && active_reg;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_reg <= '0;
    end else if (active_reg) begin
      div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
    end
  end

  timing_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_h_axis (
    .clk(clk), .reset(reset), .step(pixel_tick), .clear(!enable),
    .count(h_count), .wrap(h_wrap), .blank(h_blank), .sync_active(h_sync_active)
  );

  timing_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_v_axis (
    .clk(clk), .reset(reset), .step(h_wrap), .clear(!enable),
    .count(v_count), .wrap(v_wrap), .blank(v_blank), .sync_active(v_sync_active)
  );

  always_comb begin
    status_next = '0;
    status_next[OUTPUT_STATUS_VBLANK]  = decode_en && v_blank;
    status_next[OUTPUT_STATUS_HBLANK]  = decode_en && h_blank;
    status_next[OUTPUT_STATUS_ENABLED] = decode_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg       <= 1'b0;
      hsync_reg        <= 1'b1;
      vsync_reg        <= 1'b1;
      display_en_reg   <= 1'b0;
      status_reg       <= '0;
      line_start_reg   <= 1'b0;
      vblank_start_reg <= 1'b0;
      frame_count_reg  <= '0;
      pol_reg          <= '0;
    end else begin
      active_reg       <= enable;
      hsync_reg        <= sync_level(decode_en && h_sync_active, pol_reg.hsync_pol);
      vsync_reg        <= sync_level(decode_en && v_sync_active, pol_reg.vsync_pol);
      display_en_reg   <= decode_en && !h_blank && !v_blank;
      status_reg       <= status_next;
      line_start_reg   <= enable && h_wrap;
      vblank_start_reg <= enable && h_wrap && (v_count == V_LAST_VISIBLE);
      if (enable && v_wrap) begin
        frame_count_reg <= frame_count_reg + DATA_WIDTH'(1);
      end
      // Polarity follows the register freely while idle but only changes at frame wrap.
      if (!enable || v_wrap) begin
        pol_reg.hsync_pol <= video_mode[VIDEO_MODE_HSYNC_POL];
        pol_reg.vsync_pol <= video_mode[VIDEO_MODE_VSYNC_POL];
      end
    end
  end

  assign scan_x        = DATA_WIDTH'(h_count);
  assign scan_y        = DATA_WIDTH'(v_count);
  assign output_status = status_reg;
  assign hsync         = hsync_reg;
  assign vsync         = vsync_reg;
  assign display_en    = display_en_reg;
  assign line_start    = line_start_reg;
  assign vblank_start  = vblank_start_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: tick-count reference model, compared every clk.
module tb_video_timing;

  localparam int DW = 16;
  localparam int CD = 2;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int CW = 10;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] output_ctrl, video_mode;
  logic [DW-1:0] scan_x, scan_y, output_status, frame_count;
  logic          hsync, vsync, display_en, pixel_tick, line_start, vblank_start;

  video_timing #(
    .DATA_WIDTH(DW), .CLK_DIV(CD),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .output_ctrl(output_ctrl), .video_mode(video_mode),
    .scan_x(scan_x), .scan_y(scan_y), .output_status(output_status),
    .hsync(hsync), .vsync(vsync), .display_en(display_en), .pixel_tick(pixel_tick),
    .line_start(line_start), .vblank_start(vblank_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: position is derived from the number of pixel ticks since enable.
  bit       m_active = 1'b0;
  int       m_n      = 0;
  int       m_base   = 0;
  bit [1:0] m_pol    = 2'b00;
  bit       e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_ls = 1'b0, e_vbs = 1'b0;
  bit [2:0] e_st = 3'b000;

  function automatic int m_frames();
    return (m_base + (m_active ? (m_n / CD) / FR : 0)) % 65536;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, m_n);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit [1:0] vm);
    int t0, t1, h0, v0, p1;
    bit adv;
    if (rst) begin
      m_active = 0; m_n = 0; m_base = 0; m_pol = 2'b00;
      e_hs = 1; e_vs = 1; e_de = 0; e_st = 3'b000; e_ls = 0; e_vbs = 0;
    end else if (!en) begin
      m_base = m_frames();
      m_active = 0; m_n = 0;
      e_hs = ~m_pol[0]; e_vs = ~m_pol[1]; e_de = 0; e_st = 3'b000; e_ls = 0; e_vbs = 0;
      m_pol = vm;
    end else if (!m_active) begin
      m_active = 1; m_n = 0;
      e_hs = ~m_pol[0]; e_vs = ~m_pol[1]; e_de = 0; e_st = 3'b000; e_ls = 0; e_vbs = 0;
    end else begin
      t0 = m_n / CD;
      h0 = (t0 % FR) % HT;
      v0 = (t0 % FR) / HT;
      m_n++;
      t1 = m_n / CD;
      e_hs = (h0 >= HV + HF && h0 < HV + HF + HS) ? m_pol[0] : ~m_pol[0];
      e_vs = (v0 >= VV + VF && v0 < VV + VF + VS) ? m_pol[1] : ~m_pol[1];
      e_de = (h0 < HV) && (v0 < VV);
      e_st = {1'b1, h0 >= HV, v0 >= VV};
      adv  = (t1 > t0);
      p1   = t1 % FR;
      e_ls = adv && (p1 % HT == 0);
      e_vbs = e_ls && (p1 / HT == VV);
      if (adv && p1 == 0) m_pol = vm;
    end
  endtask

  task automatic cyc();
    int p;
    @(posedge clk);
    model_edge(reset, output_ctrl[0], video_mode[1:0]);
    #1;
    p = (m_n / CD) % FR;
    chk("scan_x", 32'(scan_x), m_active ? 32'(p % HT) : 32'd0);
    chk("scan_y", 32'(scan_y), m_active ? 32'(p / HT) : 32'd0);
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("display_en", 32'(display_en), 32'(e_de));
    chk("output_status", 32'(output_status), 32'(e_st));
    chk("pixel_tick", 32'(pixel_tick), 32'(m_active && (m_n % CD == CD - 1)));
    chk("line_start", 32'(line_start), 32'(e_ls));
    chk("vblank_start", 32'(vblank_start), 32'(e_vbs));
    chk("frame_count", 32'(frame_count), 32'(m_frames()));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cyc();
  endtask

  initial begin
    reset = 1'b1;
    output_ctrl = '0;
    video_mode = '0;
    run(3);
    reset = 1'b0;
    run(2);

    // Enable with active-low syncs; run one frame plus a few lines.
    output_ctrl = 16'($urandom) | 16'h0001;
    video_mode  = 16'($urandom) & 16'hFFFC;
    run(FR * CD + HT * CD * 3);

    // Mid-frame polarity write must wait for the next frame wrap.
    video_mode = 16'($urandom) | 16'h0003;
    run(FR * CD + HT * CD);

    // Abort mid-frame, idle briefly, then restart from (0,0).
    run($urandom_range(20, 150));
    output_ctrl = 16'($urandom) & 16'hFFFE;
    run(5);
    video_mode = 16'($urandom) & 16'hFFFC;
    run(3);
    output_ctrl = 16'($urandom) | 16'h0001;
    run(FR * CD + 7);

    // One-clk reset mid-frame with enable held.
    run($urandom_range(10, 100));
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(FR * CD + 20);

    // Random mix of polarity writes, enable toggles and short resets.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: video_mode = 16'($urandom);
        1: output_ctrl = 16'($urandom);
        2: output_ctrl = 16'($urandom) | 16'h0001;
        3: begin reset = 1'b1; run(1); reset = 1'b0; end
        default: ;
      endcase
      run($urandom_range(1, 120));
    end
    output_ctrl = 16'h0001;
    run(FR * CD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
